executor: RTL and testbench

Execute stage of the Bully core, directly downstream of `decoder`. It samples each decoded command on `cmd_ready` and updates an internal general-purpose register file and compare flags. It issues PC redirects to the fetch side, raises and holds interrupt requests until acknowledged, and tracks halt, protected mode and fault state. Every command retires in one cycle, which keeps pace with `decoder`'s fastest issue rate of one CTL/INT command per cycle.

---
 rtl/bully_pkg.sv | 41 ++++
 rtl/executor_regfile.sv | 41 ++++
 rtl/executor.sv | 255 +++++++++++++++++++++++++
 tb/tb_executor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bully_pkg.sv
// Shared Bully core definitions: command type/opcode encodings, PC redirect
// modes and the executor state encoding, used by decoder and executor alike.
package bully_pkg;

    localparam logic [2:0] CODE_TYPE_INT = 3'b000;
    localparam logic [2:0] CODE_TYPE_REG = 3'b001;
    localparam logic [2:0] CODE_TYPE_IMM = 3'b010;
    localparam logic [2:0] CODE_TYPE_JMP = 3'b100;
    localparam logic [2:0] CODE_TYPE_CTL = 3'b111;

    // REG / IMM opcodes
    localparam logic [2:0] CODE_OPCD_MOV = 3'd0;
    localparam logic [2:0] CODE_OPCD_ADD = 3'd1;
    localparam logic [2:0] CODE_OPCD_SUB = 3'd2;
    localparam logic [2:0] CODE_OPCD_AND = 3'd3;
    localparam logic [2:0] CODE_OPCD_OR  = 3'd4;
    localparam logic [2:0] CODE_OPCD_XOR = 3'd5;
    localparam logic [2:0] CODE_OPCD_CMP = 3'd6;

    // JMP opcodes
    localparam logic [2:0] CODE_OPCD_JMP = 3'd0;
    localparam logic [2:0] CODE_OPCD_JE  = 3'd1;
    localparam logic [2:0] CODE_OPCD_JG  = 3'd2;
    localparam logic [2:0] CODE_OPCD_SJF = 3'd3;
    localparam logic [2:0] CODE_OPCD_SJB = 3'd4;

    // CTL opcode 0 halts; any other value enters protected mode
    localparam logic [2:0] CODE_OPCD_HLT = 3'd0;

    localparam logic [1:0] PC_MODE_ABS  = 2'b00;
    localparam logic [1:0] PC_MODE_FWD  = 2'b01;
    localparam logic [1:0] PC_MODE_BACK = 2'b10;

    typedef enum logic [1:0] {
        EXEC_RUN,
        EXEC_INT_WAIT,
        EXEC_HALT,
        EXEC_FAULT
    } exec_state_t;

endpackage

// File: rtl/executor_regfile.sv
// General-purpose register file: two combinational operand reads, one debug
// read, one synchronous write port; every register clears on reset.
module executor_regfile #(
    parameter int BUS_WIDTH = 32,
    parameter int REG_COUNT = 16,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr_a,
    input  logic [AW-1:0]        raddr_b,
    input  logic [AW-1:0]        dbg_addr,
    output logic [BUS_WIDTH-1:0] rdata_a,
    output logic [BUS_WIDTH-1:0] rdata_b,
    output logic [BUS_WIDTH-1:0] dbg_data
);

    logic [BUS_WIDTH-1:0] regs [REG_COUNT];

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
        logic [BUS_WIDTH-1:0] val_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                val_q <= '0;
            end else if (we && (waddr == AW'(gi))) begin
                val_q <= wdata;
            end
        end

        assign regs[gi] = val_q;
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/executor.sv
// Bully execute stage: retires one decoded command per cycle, updating the
// register file, compare flags, PC redirects, interrupt and control state.
module executor
    import bully_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int REG_COUNT = 16,
    parameter int PROT_REGS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         admin_flag,
    input  logic [2:0]                   code_type,
    input  logic [BUS_WIDTH-5:0]         opcode,
    input  logic [BUS_WIDTH-1:0]         opdata0,
    input  logic [BUS_WIDTH-1:0]         opdata1,
    input  logic                         cmd_ready,
    input  logic                         int_ack,
    input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
    output logic [BUS_WIDTH-1:0]         dbg_data,
    output logic                         pc_load,
    output logic [1:0]                   pc_mode,
    output logic [BUS_WIDTH-1:0]         pc_value,
    output logic                         int_req,
    output logic [BUS_WIDTH-5:0]         int_vector,
    output logic                         int_admin,
    output logic                         flag_eq,
    output logic                         flag_gt,
    output logic                         protected_mode,
    output logic [BUS_WIDTH-5:0]         prot_addr,
    output logic                         halted,
    output logic                         exec_error
);

    localparam int AW = $clog2(REG_COUNT);
    localparam int OW = BUS_WIDTH - 4;

    exec_state_t          state_q, state_d;
    logic                 pc_load_q, pc_load_d;
    logic [1:0]           pc_mode_q, pc_mode_d;
    logic [BUS_WIDTH-1:0] pc_value_q, pc_value_d;
    logic                 int_req_q, int_req_d;
    logic [OW-1:0]        int_vector_q, int_vector_d;
    logic                 int_admin_q, int_admin_d;
    logic                 flag_eq_q, flag_eq_d;
    logic                 flag_gt_q, flag_gt_d;
    logic                 prot_q, prot_d;
    logic [OW-1:0]        prot_addr_q, prot_addr_d;
    logic                 exec_error_q, exec_error_d;

    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [BUS_WIDTH-1:0] rf_wdata;
    logic [BUS_WIDTH-1:0] rd_a, rd_b;
    logic                 fault;
    logic                 jmp_take;

    executor_regfile #(
        .BUS_WIDTH(BUS_WIDTH),
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (opdata0[AW-1:0]),
        .raddr_b (opdata1[AW-1:0]),
        .dbg_addr(dbg_addr),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .dbg_data(dbg_data)
    );

    // Register addresses span the whole operand, so upper bits must be zero.
    logic [2:0] op3;
    logic       op_hi;
    logic       a_bad, b_bad, a_prot, b_prot;
    assign op3    = opcode[2:0];
    assign op_hi  = |opcode[OW-1:3];
    assign a_bad  = opdata0 >= BUS_WIDTH'(REG_COUNT);
    assign b_bad  = opdata1 >= BUS_WIDTH'(REG_COUNT);
    assign a_prot = opdata0 < BUS_WIDTH'(PROT_REGS);
    assign b_prot = opdata1 < BUS_WIDTH'(PROT_REGS);

    function automatic logic [BUS_WIDTH-1:0] alu(input logic [2:0] op,
                                                 input logic [BUS_WIDTH-1:0] x,
                                                 input logic [BUS_WIDTH-1:0] y);
        case (op)
            CODE_OPCD_ADD: alu = x + y;
            CODE_OPCD_SUB: alu = x - y;
            CODE_OPCD_AND: alu = x & y;
            CODE_OPCD_OR:  alu = x | y;
            CODE_OPCD_XOR: alu = x ^ y;
            default:       alu = y;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        pc_load_d    = 1'b0;
        pc_mode_d    = 2'b00;
        pc_value_d   = '0;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        int_admin_d  = int_admin_q;
        flag_eq_d    = flag_eq_q;
        flag_gt_d    = flag_gt_q;
        prot_d       = prot_q;
        prot_addr_d  = prot_addr_q;
        exec_error_d = exec_error_q;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        fault        = 1'b0;
        jmp_take     = 1'b0;

        case (state_q)
            EXEC_RUN: begin
                if (cmd_ready) begin
                    case (code_type)
                        CODE_TYPE_REG: begin
                            if (op_hi || op3 == 3'd7 || a_bad || b_bad) begin
                                fault = 1'b1;
                            end else if (op3 == CODE_OPCD_CMP) begin
                                flag_eq_d = (rd_a == rd_b);
                                flag_gt_d = (rd_a > rd_b);
                            end else if (prot_q && !admin_flag && b_prot) begin
                                fault = 1'b1;
                            end else begin
                                rf_we    = 1'b1;
                                rf_waddr = opdata1[AW-1:0];
                                rf_wdata = (op3 == CODE_OPCD_MOV) ? rd_a : alu(op3, rd_a, rd_b);
                            end
                        end
                        CODE_TYPE_IMM: begin
                            if (op_hi || op3 == 3'd7 || a_bad) begin
                                fault = 1'b1;
                            end else if (op3 == CODE_OPCD_CMP) begin
                                flag_eq_d = (rd_a == opdata1);
                                flag_gt_d = (opdata1 > rd_a);
                            end else if (prot_q && !admin_flag && a_prot) begin
                                fault = 1'b1;
                            end else begin
                                rf_we    = 1'b1;
                                rf_waddr = opdata0[AW-1:0];
                                rf_wdata = alu(op3, rd_a, opdata1);
                            end
                        end
                        CODE_TYPE_JMP: begin
                            if (op_hi || op3 > CODE_OPCD_SJB) begin
                                fault = 1'b1;
                            end else if (op3 <= CODE_OPCD_JG && a_bad) begin
                                fault = 1'b1;
                            end else begin
                                case (op3)
                                    CODE_OPCD_JMP: jmp_take = 1'b1;
                                    CODE_OPCD_JE:  jmp_take = flag_eq_q;
                                    CODE_OPCD_JG:  jmp_take = flag_gt_q;
                                    default:       jmp_take = 1'b0;
                                endcase
                                if (op3 == CODE_OPCD_SJF || op3 == CODE_OPCD_SJB) begin
                                    pc_load_d  = 1'b1;
                                    pc_mode_d  = (op3 == CODE_OPCD_SJF) ? PC_MODE_FWD : PC_MODE_BACK;
                                    pc_value_d = opdata0;
                                end else if (jmp_take) begin
                                    pc_load_d  = 1'b1;
                                    pc_mode_d  = PC_MODE_ABS;
                                    pc_value_d = rd_a;
                                end
                            end
                        end
                        CODE_TYPE_INT: begin
                            int_req_d    = 1'b1;
                            int_vector_d = opcode;
                            int_admin_d  = admin_flag;
                            state_d      = EXEC_INT_WAIT;
                        end
                        CODE_TYPE_CTL: begin
                            if (!admin_flag) begin
                                fault = 1'b1;
                            end else if (opcode == OW'(CODE_OPCD_HLT)) begin
                                state_d = EXEC_HALT;
                            end else begin
                                prot_d      = 1'b1;
                                prot_addr_d = opcode;
                            end
                        end
                        default: fault = 1'b1;
                    endcase
                end
            end
            EXEC_INT_WAIT: begin
                // An ack is honoured even when an overrun command arrives alongside it.
                if (int_ack) begin
                    int_req_d = 1'b0;
                    state_d   = EXEC_RUN;
                end
                if (cmd_ready) begin
                    fault = 1'b1;
                end
            end
            default: ;
        endcase

        if (fault) begin
            state_d      = EXEC_FAULT;
            exec_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EXEC_RUN;
            pc_load_q    <= 1'b0;
            pc_mode_q    <= 2'b00;
            pc_value_q   <= '0;
            int_req_q    <= 1'b0;
            int_vector_q <= '0;
            int_admin_q  <= 1'b0;
            flag_eq_q    <= 1'b0;
            flag_gt_q    <= 1'b0;
            prot_q       <= 1'b0;
            prot_addr_q  <= '0;
            exec_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_load_q    <= pc_load_d;
            pc_mode_q    <= pc_mode_d;
            pc_value_q   <= pc_value_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            int_admin_q  <= int_admin_d;
            flag_eq_q    <= flag_eq_d;
            flag_gt_q    <= flag_gt_d;
            prot_q       <= prot_d;
            prot_addr_q  <= prot_addr_d;
            exec_error_q <= exec_error_d;
        end
    end

    assign pc_load        = pc_load_q;
    assign pc_mode        = pc_mode_q;
    assign pc_value       = pc_value_q;
    assign int_req        = int_req_q;
    assign int_vector     = int_vector_q;
    assign int_admin      = int_admin_q;
    assign flag_eq        = flag_eq_q;
    assign flag_gt        = flag_gt_q;
    assign protected_mode = prot_q;
    assign prot_addr      = prot_addr_q;
    assign halted         = (state_q == EXEC_HALT);
    assign exec_error     = exec_error_q;

endmodule

// File: tb/tb_executor.sv
// Directed bench for executor: hand-computed vectors, one line per command.
module tb_executor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        admin_flag = 1'b0;
    logic [2:0]  code_type = 3'b000;
    logic [27:0] opcode = '0;
    logic [31:0] opdata0 = '0;
    logic [31:0] opdata1 = '0;
    logic        cmd_ready = 1'b0;
    logic        int_ack = 1'b0;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        pc_load;
    logic [1:0]  pc_mode;
    logic [31:0] pc_value;
    logic        int_req;
    logic [27:0] int_vector;
    logic        int_admin;
    logic        flag_eq, flag_gt;
    logic        protected_mode;
    logic [27:0] prot_addr;
    logic        halted;
    logic        exec_error;

    int total = 0;
    int bad = 0;

    localparam logic [2:0] T_INT = 3'b000, T_REG = 3'b001, T_IMM = 3'b010,
                           T_JMP = 3'b100, T_CTL = 3'b111;

    executor dut (
        .clk(clk), .reset(reset), .admin_flag(admin_flag), .code_type(code_type),
        .opcode(opcode), .opdata0(opdata0), .opdata1(opdata1), .cmd_ready(cmd_ready),
        .int_ack(int_ack), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pc_load(pc_load), .pc_mode(pc_mode), .pc_value(pc_value),
        .int_req(int_req), .int_vector(int_vector), .int_admin(int_admin),
        .flag_eq(flag_eq), .flag_gt(flag_gt), .protected_mode(protected_mode),
        .prot_addr(prot_addr), .halted(halted), .exec_error(exec_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Drive one command for a single rising edge, then sample 1ns after it.
    task automatic cmd(input logic adm, input logic [2:0] ct, input logic [27:0] op,
                       input logic [31:0] d0, input logic [31:0] d1);
        admin_flag = adm; code_type = ct; opcode = op; opdata0 = d0; opdata1 = d1;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        $display("cmd t=%0t adm=%0b type=%03b op=0x%0h d0=0x%0h d1=0x%0h", $time, adm, ct, op, d0, d1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_int_req", 32'(int_req), 32'd0);
        check("rst_flags", {30'd0, flag_eq, flag_gt}, 32'd0);
        check("rst_prot", {3'd0, protected_mode, prot_addr}, 32'd0);
        check("rst_halt_err", {30'd0, halted, exec_error}, 32'd0);
        chk_reg("rst_r0", 4'd0, 32'd0);

        // Arithmetic with wrap
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'd5);
        cmd(1'b0, T_IMM, 28'd0, 32'd2, 32'd3);
        chk_reg("mov_r1", 4'd1, 32'd5);
        cmd(1'b0, T_REG, 28'd1, 32'd1, 32'd2);
        chk_reg("add_r2", 4'd2, 32'd8);
        cmd(1'b0, T_REG, 28'd2, 32'd1, 32'd2);
        chk_reg("sub_wrap_r2", 4'd2, 32'hFFFF_FFFD);
        cmd(1'b0, T_IMM, 28'd0, 32'd3, 32'd6);
        cmd(1'b0, T_REG, 28'd1, 32'd3, 32'd3);
        chk_reg("add_self_r3", 4'd3, 32'd12);

        // Compare and jumps
        cmd(1'b0, T_IMM, 28'd6, 32'd1, 32'd7);
        check("cmp_gt", 32'(flag_gt), 32'd1);
        check("cmp_eq", 32'(flag_eq), 32'd0);
        cmd(1'b0, T_IMM, 28'd0, 32'd2, 32'h40);
        check("flags_hold", {30'd0, flag_eq, flag_gt}, 32'd1);
        cmd(1'b0, T_JMP, 28'd2, 32'd2, 32'd0);
        check("jg_load", 32'(pc_load), 32'd1);
        check("jg_mode", 32'(pc_mode), 32'd0);
        check("jg_value", pc_value, 32'h40);
        tick();
        check("jg_one_pulse", 32'(pc_load), 32'd0);
        cmd(1'b0, T_JMP, 28'd1, 32'd2, 32'd0);
        check("je_not_taken", 32'(pc_load), 32'd0);
        cmd(1'b0, T_JMP, 28'd4, 32'd3, 32'd0);
        check("sjb_load", 32'(pc_load), 32'd1);
        check("sjb_mode", 32'(pc_mode), 32'd2);
        check("sjb_value", pc_value, 32'd3);

        // Back-to-back: ADD sees the MOV from the previous cycle
        admin_flag = 1'b0; code_type = T_IMM; opcode = 28'd0; opdata0 = 32'd5; opdata1 = 32'd10;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        code_type = T_REG; opcode = 28'd1; opdata0 = 32'd5; opdata1 = 32'd5;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        $display("cmd t=%0t back-to-back MOV 10->R5, ADD R5,R5", $time);
        chk_reg("b2b_r5", 4'd5, 32'd20);
        cmd(1'b0, T_IMM, 28'd6, 32'd5, 32'd20);
        check("cmp_eq_flags", {30'd0, flag_eq, flag_gt}, 32'd2);
        cmd(1'b0, T_IMM, 28'd5, 32'd1, 32'hF);
        chk_reg("xor_r1", 4'd1, 32'hA);

        // Illegal JMP opcode faults; later commands ignored
        cmd(1'b0, T_JMP, 28'd5, 32'd0, 32'd0);
        check("bad_jmp_err", 32'(exec_error), 32'd1);
        check("bad_jmp_noload", 32'(pc_load), 32'd0);
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'h77);
        chk_reg("fault_ignored_r1", 4'd1, 32'hA);

        // Interrupt then overrun
        do_reset();
        cmd(1'b0, T_INT, 28'd9, 32'd0, 32'd0);
        check("int_req", 32'(int_req), 32'd1);
        check("int_vector", 32'(int_vector), 32'd9);
        check("int_admin", 32'(int_admin), 32'd0);
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'd1);
        check("overrun_err", 32'(exec_error), 32'd1);
        chk_reg("overrun_r1", 4'd1, 32'd0);

        // Interrupt acknowledged 4 cycles later
        do_reset();
        cmd(1'b1, T_INT, 28'd9, 32'd0, 32'd0);
        check("int_admin_set", 32'(int_admin), 32'd1);
        repeat (3) tick();
        check("int_req_held", 32'(int_req), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("int_acked", 32'(int_req), 32'd0);
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'd2);
        cmd(1'b0, T_REG, 28'd1, 32'd1, 32'd1);
        chk_reg("post_ack_add", 4'd1, 32'd4);
        check("post_ack_noerr", 32'(exec_error), 32'd0);

        // Protected mode
        do_reset();
        cmd(1'b1, T_CTL, 28'h100, 32'd0, 32'd0);
        check("pro_mode", 32'(protected_mode), 32'd1);
        check("pro_addr", 32'(prot_addr), 32'h100);
        check("pro_not_halted", 32'(halted), 32'd0);
        cmd(1'b1, T_IMM, 28'd0, 32'd2, 32'h55);
        chk_reg("admin_mov_r2", 4'd2, 32'h55);
        cmd(1'b0, T_IMM, 28'd0, 32'd5, 32'd1);
        chk_reg("user_mov_r5", 4'd5, 32'd1);
        cmd(1'b0, T_REG, 28'd0, 32'd2, 32'd6);
        chk_reg("user_read_prot", 4'd6, 32'h55);
        check("user_ok_noerr", 32'(exec_error), 32'd0);
        cmd(1'b0, T_IMM, 28'd0, 32'd2, 32'h99);
        check("user_prot_err", 32'(exec_error), 32'd1);
        chk_reg("user_prot_r2", 4'd2, 32'h55);

        // Out-of-range register address
        do_reset();
        cmd(1'b0, T_IMM, 28'd0, 32'd16, 32'h33);
        check("addr_err", 32'(exec_error), 32'd1);
        chk_reg("addr_r0", 4'd0, 32'd0);

        // CTL from user mode faults
        do_reset();
        cmd(1'b0, T_CTL, 28'd0, 32'd0, 32'd0);
        check("ctl_user_err", {30'd0, halted, exec_error}, 32'd1);

        // Halt and asynchronous reset out of it
        do_reset();
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'h21);
        cmd(1'b1, T_CTL, 28'd0, 32'd0, 32'd0);
        check("halted", 32'(halted), 32'd1);
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'd7);
        chk_reg("halt_ignored_r1", 4'd1, 32'h21);
        reset = 1'b1;
        #1;
        check("async_rst_halt", {30'd0, halted, exec_error}, 32'd0);
        chk_reg("async_rst_r1", 4'd1, 32'd0);
        reset = 1'b0;
        tick();
        cmd(1'b0, T_IMM, 28'd0, 32'd1, 32'd7);
        chk_reg("run_after_rst", 4'd1, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
